// File: rtl/id_operand_scoreboard.sv
// id_operand_scoreboard: decode-stage per-register latency scoreboard and N-source forwarding mux.
// Optional feature macro ID_SB_STATS_EN adds stall_cnt_o, a free-running count of effective ID stall cycles.
module id_operand_scoreboard #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NFWD = 3,
    parameter int LW   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic [AW-1:0]     id_rs_i,
    input  logic [AW-1:0]     id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              id_early_i,
    input  logic              id_issue_i,
    input  logic              id_wreg_i,
    input  logic [AW-1:0]     id_waddr_i,
    input  logic [LW-1:0]     id_lat_i,
    input  logic [DW-1:0]     rf_data1_i,
    input  logic [DW-1:0]     rf_data2_i,
    input  logic [NFWD-1:0]   fwd_we_i,
    input  logic [NFWD*AW-1:0] fwd_waddr_i,
    input  logic [NFWD*DW-1:0] fwd_wdata_i,
    output logic [DW-1:0]     rdata1_o,
    output logic [DW-1:0]     rdata2_o,
    output logic              stall_o
`ifdef ID_SB_STATS_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);
    localparam int NREG = 2**AW;
    logic [LW-1:0] cnt_q [NREG];
    logic [LW-1:0] cnt_d [NREG];
    logic          issue_eff;
    // Early consumers need the value now; late consumers can still catch a count of 1 on the EX port.
    function automatic logic src_stall(input logic use_s, input logic [AW-1:0] s,
                                       input logic [LW-1:0] c, input logic early);
        return use_s && (s != '0) && (early ? (c != '0) : (c > LW'(1)));
    endfunction
    // Scan oldest to youngest so the lowest-index matching port overrides.
    function automatic logic [DW-1:0] fwd_sel(input logic [AW-1:0] a, input logic [DW-1:0] rf,
                                              input logic [NFWD-1:0] we,
                                              input logic [NFWD*AW-1:0] wa,
                                              input logic [NFWD*DW-1:0] wd);
        logic [DW-1:0] v;
        v = rf;
        for (int k = NFWD - 1; k >= 0; k--)
            if (we[k] && (wa[k*AW+:AW] == a)) v = wd[k*DW+:DW];
        return (a == '0) ? '0 : v;
    endfunction
    assign rdata1_o  = fwd_sel(id_rs_i, rf_data1_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i);
    assign rdata2_o  = fwd_sel(id_rt_i, rf_data2_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i);
    assign stall_o   = ~flush_i & (src_stall(id_use_rs_i, id_rs_i, cnt_q[id_rs_i], id_early_i) |
                                   src_stall(id_use_rt_i, id_rt_i, cnt_q[id_rt_i], id_early_i));
    assign issue_eff = id_issue_i & ~stall_o & ~hold_i;
    // Next counter values: flush clears, hold freezes, else count down with the new producer's load winning.
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++)
            cnt_d[r] = flush_i ? '0 :
                       hold_i  ? cnt_q[r] :
                       (issue_eff && id_wreg_i && (id_waddr_i == AW'(r))) ? id_lat_i :
                       (cnt_q[r] != '0) ? cnt_q[r] - LW'(1) : '0;
    end
    // Scoreboard state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '{default: '0};
        else       cnt_q <= cnt_d;
    end
`ifdef ID_SB_STATS_EN
    logic [31:0] stall_cnt_q;
    // Count cycles where ID is genuinely blocked by the scoreboard.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          stall_cnt_q <= '0;
        else if (stall_o & ~hold_i & ~flush_i) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_id_operand_scoreboard.sv
// tb_id_operand_scoreboard: directed bench with a per-register "cycles until forwardable" model checked every cycle.
module tb_id_operand_scoreboard;
    logic        clk_i = 0, rst_i = 1, hold_i = 0, flush_i = 0;
    logic [4:0]  id_rs_i = 0, id_rt_i = 0, id_waddr_i = 0;
    logic        id_use_rs_i = 0, id_use_rt_i = 0, id_early_i = 0, id_issue_i = 0, id_wreg_i = 0;
    logic [2:0]  id_lat_i = 0;
    logic [31:0] rf_data1_i = 32'hAAAA0001, rf_data2_i = 32'hBBBB0002;
    logic [2:0]  fwd_we_i = 0;
    logic [14:0] fwd_waddr_i = 0;
    logic [95:0] fwd_wdata_i = 0;
    logic [31:0] rdata1_o, rdata2_o;
    logic        stall_o;
`ifdef ID_SB_STATS_EN
    logic [31:0] stall_cnt_o;
`endif
    int cmp_n = 0, err_n = 0;
    int rem [32];

    id_operand_scoreboard dut (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
        .id_early_i(id_early_i), .id_issue_i(id_issue_i), .id_wreg_i(id_wreg_i),
        .id_waddr_i(id_waddr_i), .id_lat_i(id_lat_i), .rf_data1_i(rf_data1_i), .rf_data2_i(rf_data2_i),
        .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
        .rdata1_o(rdata1_o), .rdata2_o(rdata2_o), .stall_o(stall_o)
`ifdef ID_SB_STATS_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic bit m_need(input bit u, input int s);
        if (!u || s == 0) return 0;
        return id_early_i ? (rem[s] > 0) : (rem[s] > 1);
    endfunction
    function automatic bit m_stall();
        if (flush_i) return 0;
        return m_need(id_use_rs_i, id_rs_i) || m_need(id_use_rt_i, id_rt_i);
    endfunction
    function automatic logic [31:0] m_fwd(input int a, input logic [31:0] rf);
        if (a == 0) return 0;
        for (int k = 0; k < 3; k++)
            if (fwd_we_i[k] && fwd_waddr_i[k*5+:5] == 5'(a)) return fwd_wdata_i[k*32+:32];
        return rf;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            for (int r = 0; r < 32; r++) rem[r] = 0;
        end else if (!hold_i) begin
            bit go;
            go = id_issue_i && !m_stall();
            for (int r = 0; r < 32; r++) if (rem[r] > 0) rem[r] = rem[r] - 1;
            if (go && id_wreg_i && id_waddr_i != 0) rem[id_waddr_i] = id_lat_i;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) if (!rst_i) begin
        chk("model_stall", 32'(stall_o), 32'(m_stall()));
        chk("model_rdata1", rdata1_o, m_fwd(id_rs_i, rf_data1_i));
        chk("model_rdata2", rdata2_o, m_fwd(id_rt_i, rf_data2_i));
    end

    task automatic cyc();
        @(posedge clk_i); #1;
    endtask
    task automatic idle();
        {id_issue_i, id_wreg_i, id_use_rs_i, id_use_rt_i, id_early_i} = '0;
        {id_rs_i, id_rt_i, id_waddr_i, id_lat_i} = '0;
        {hold_i, flush_i, fwd_we_i, fwd_waddr_i, fwd_wdata_i} = '0;
    endtask
    task automatic wr(input logic [4:0] d, input logic [2:0] lat);
        idle(); id_issue_i = 1; id_wreg_i = 1; id_waddr_i = d; id_lat_i = lat;
    endtask
    task automatic rd(input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt, input bit early);
        idle(); id_issue_i = 1; id_rs_i = rs; id_rt_i = rt;
        id_use_rs_i = urs; id_use_rt_i = urt; id_early_i = early;
    endtask
    task automatic port(input int k, input logic [4:0] a, input logic [31:0] d);
        fwd_we_i[k] = 1; fwd_waddr_i[k*5+:5] = a; fwd_wdata_i[k*32+:32] = d;
    endtask

    initial begin
        idle(); id_rs_i = 5'd4;
        #12 rst_i = 0; #1;
        chk("reset_stall", 32'(stall_o), 0);
        chk("reset_rf_pass", rdata1_o, 32'hAAAA0001);
        // load r5 lat 2, then beq r5,r0
        cyc(); wr(5, 2);
        cyc(); rd(5, 0, 1, 1, 1); #1 chk("s1_stall_a", 32'(stall_o), 1);
        cyc(); chk("s1_stall_b", 32'(stall_o), 1);
        cyc(); port(1, 5, 32'hDEADBEEF); #1;
        chk("s1_release", 32'(stall_o), 0);
        chk("s1_mem_fwd", rdata1_o, 32'hDEADBEEF);
        chk("s1_r0", rdata2_o, 0);
`ifdef ID_SB_STATS_EN
        chk("s6_stall_cnt", stall_cnt_o, 2);
`endif
        // ALU r3 then add r4,r3,r3
        cyc(); wr(3, 1);
        cyc(); rd(3, 3, 1, 1, 0); id_wreg_i = 1; id_waddr_i = 4; id_lat_i = 1; port(0, 3, 32'h11); #1;
        chk("s2_stall", 32'(stall_o), 0);
        chk("s2_rd1", rdata1_o, 32'h11);
        chk("s2_rd2", rdata2_o, 32'h11);
        // three ports write r7; r0 with ports addressing r0; rf fallback
        cyc(); idle(); id_rs_i = 7; id_rt_i = 6; port(0, 7, 1); port(1, 7, 2); port(2, 7, 3); #1;
        chk("s3_youngest", rdata1_o, 1);
        chk("s3_rf_fallback", rdata2_o, 32'hBBBB0002);
        fwd_we_i[0] = 0; #1 chk("s3_mem_next", rdata1_o, 2);
        idle(); id_rs_i = 0; port(0, 0, 1); port(1, 0, 2); port(2, 0, 3); #1;
        chk("s3_r0", rdata1_o, 0);
        // div r8 lat 5, 3 held cycles, then jr r8
        cyc(); wr(8, 5);
        cyc(); rd(8, 0, 1, 0, 1); hold_i = 1;
        for (int i = 0; i < 3; i++) begin #1 chk("s4_held", 32'(stall_o), 1); cyc(); end
        hold_i = 0;
        for (int i = 0; i < 5; i++) begin #1 chk("s4_unheld", 32'(stall_o), 1); cyc(); end
        #1 chk("s4_release", 32'(stall_o), 0);
        // mul r9 lat 4, flush, then jr r9
        cyc(); wr(9, 4);
        cyc(); rd(9, 0, 1, 0, 1); #1 chk("s5_pending", 32'(stall_o), 1);
        id_issue_i = 0; flush_i = 1; #1 chk("s5_flush_gate", 32'(stall_o), 0);
        cyc(); rd(9, 0, 1, 0, 1); #1 chk("s5_flushed", 32'(stall_o), 0);
        // lat 0 never pending; WAW reload shortens the wait
        cyc(); wr(10, 0);
        cyc(); rd(10, 0, 1, 0, 1); #1 chk("lat0", 32'(stall_o), 0);
        cyc(); wr(11, 7);
        cyc(); wr(11, 1);
        cyc(); rd(11, 0, 1, 0, 0); #1 chk("waw_late", 32'(stall_o), 0);
        id_early_i = 1; #1 chk("waw_early", 32'(stall_o), 1);
        // async reset mid-stall
        cyc(); wr(9, 6);
        cyc(); rd(9, 0, 1, 0, 1); #1 chk("rst_pre", 32'(stall_o), 1);
        #1 rst_i = 1; #1 chk("rst_async", 32'(stall_o), 0);
        #1 rst_i = 0;
        cyc(); #1 chk("rst_after", 32'(stall_o), 0);
        cyc(); idle(); cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
